ddr3_burst_engine: RTL and testbench

Downstream neighbour of the DDR3 read/write scheduler. It takes that scheduler's burst commands and executes them on the DDR3 controller's AXI-style port:
- wd_req/wd_addr/wd_len become AW + W bursts fed from the write FIFO.
- rd_req/rd_addr/rd_len become AR + R bursts pushed into the read FIFO.
- On completion it returns a one-cycle wd_finish/rd_finish pulse.
- Commands longer than MAX_BEATS are split into back-to-back sub-bursts.

---
 rtl/ddr3_pkg.sv | 7 +
 rtl/ddr3_burst_engine_if.sv | 34 +++
 rtl/ddr3_burst_split.sv | 33 +++
 rtl/ddr3_burst_engine.sv | 113 +++++++++++
 tb/tb_ddr3_burst_engine.sv | 348 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ddr3_pkg.sv
// ddr3_pkg: shared state encoding, AXI length width and default tuning for the DDR3 burst engine
package ddr3_pkg;
  localparam int AXI_LEN_W = 8;
  localparam int DEF_MAX_BEATS = 16;
  localparam int DEF_GUARD_CYC = 4;
  typedef enum logic [2:0] {S_IDLE, S_WA, S_WD, S_RA, S_RD, S_FIN, S_GUARD} state_t;
endpackage

// File: rtl/ddr3_burst_engine_if.sv
// ddr3_burst_engine_if: AXI-style AW/W/AR/R channels between the burst engine and the DDR3 controller
// master (engine): drives aw*/w*/ar* payload and valids, receives readies and r* data
// slave (controller): the mirror image
interface ddr3_burst_engine_if import ddr3_pkg::*; #(
  parameter int DATA_W = 256,
  parameter int ADDR_W = 28
) ();
  logic [ADDR_W-1:0] axi_awaddr;
  logic [AXI_LEN_W-1:0] axi_awlen;
  logic axi_awvalid;
  logic axi_awready;
  logic [DATA_W-1:0] axi_wdata;
  logic [DATA_W/8-1:0] axi_wstrb;
  logic axi_wvalid;
  logic axi_wready;
  logic axi_wlast;
  logic [ADDR_W-1:0] axi_araddr;
  logic [AXI_LEN_W-1:0] axi_arlen;
  logic axi_arvalid;
  logic axi_arready;
  logic [DATA_W-1:0] axi_rdata;
  logic axi_rvalid;
  logic axi_rlast;
  modport master (
    output axi_awaddr, axi_awlen, axi_awvalid, axi_wdata, axi_wstrb, axi_wvalid, axi_wlast,
    output axi_araddr, axi_arlen, axi_arvalid,
    input axi_awready, axi_wready, axi_arready, axi_rdata, axi_rvalid, axi_rlast
  );
  modport slave (
    input axi_awaddr, axi_awlen, axi_awvalid, axi_wdata, axi_wstrb, axi_wvalid, axi_wlast,
    input axi_araddr, axi_arlen, axi_arvalid,
    output axi_awready, axi_wready, axi_arready, axi_rdata, axi_rvalid, axi_rlast
  );
endinterface

// File: rtl/ddr3_burst_split.sv
// ddr3_burst_split: walks a latched command (start, len) through sub-bursts of at most MAX_BEATS beats
// in: clk, rst, load (latch start/len), next (current sub-burst done), start, len
// out: addr (sub-burst start, wraps mod 2^ADDR_W), sub_len (beats-1), remaining (beats left incl. current)
module ddr3_burst_split import ddr3_pkg::*; #(
  parameter int ADDR_W = 28,
  parameter int MAX_BEATS = DEF_MAX_BEATS
) (
  input logic clk,
  input logic rst,
  input logic load,
  input logic next,
  input logic [ADDR_W-1:0] start,
  input logic [9:0] len,
  output logic [ADDR_W-1:0] addr,
  output logic [AXI_LEN_W-1:0] sub_len,
  output logic [9:0] remaining
);
  logic [9:0] sub;
  assign sub = remaining > 10'(MAX_BEATS) ? 10'(MAX_BEATS) : remaining;
  // an empty command reports len 0 rather than wrapping to 255
  assign sub_len = sub == '0 ? '0 : AXI_LEN_W'(sub - 10'd1);
  always_ff @(posedge clk)
    if (rst) begin
      addr <= '0;
      remaining <= '0;
    end else if (load) begin
      addr <= start;
      remaining <= len;
    end else if (next) begin
      addr <= addr + ADDR_W'(sub);
      remaining <= remaining - sub;
    end
endmodule

// File: rtl/ddr3_burst_engine.sv
// ddr3_burst_engine: executes scheduler write/read burst commands as AXI AW+W / AR+R sub-bursts
// in: clk, rst, ddr3_init_done, wd_req/wd_addr/wd_len, rd_req/rd_addr/rd_len, wfifo_rd_data
// out: wd_finish/rd_finish pulses, wfifo_rd_en pop, rfifo_wr_en/rfifo_wr_data push, err_rlast (sticky)
// axi: master side of ddr3_burst_engine_if
module ddr3_burst_engine import ddr3_pkg::*; #(
  parameter int DATA_W = 256,
  parameter int ADDR_W = 28,
  parameter int MAX_BEATS = DEF_MAX_BEATS,
  parameter int GUARD_CYC = DEF_GUARD_CYC
) (
  input logic clk,
  input logic rst,
  input logic ddr3_init_done,
  input logic wd_req,
  input logic [ADDR_W-1:0] wd_addr,
  input logic [9:0] wd_len,
  output logic wd_finish,
  input logic rd_req,
  input logic [ADDR_W-1:0] rd_addr,
  input logic [9:0] rd_len,
  output logic rd_finish,
  output logic wfifo_rd_en,
  input logic [DATA_W-1:0] wfifo_rd_data,
  output logic rfifo_wr_en,
  output logic [DATA_W-1:0] rfifo_wr_data,
  ddr3_burst_engine_if.master axi,
  output logic err_rlast
);
  state_t state;
  logic is_wr;
  logic [AXI_LEN_W-1:0] beat;
  logic [15:0] gcnt;
  logic load;
  logic next;
  logic last_sub;
  logic w_hs;
  logic r_beat;
  logic [ADDR_W-1:0] sub_addr;
  logic [AXI_LEN_W-1:0] sub_len;
  logic [9:0] remaining;
  assign load = state == S_IDLE && ddr3_init_done && (wd_req || rd_req);
  assign w_hs = axi.axi_wvalid && axi.axi_wready;
  assign r_beat = state == S_RD && axi.axi_rvalid;
  assign next = (w_hs || r_beat) && beat == sub_len;
  assign last_sub = remaining <= 10'(MAX_BEATS);
  ddr3_burst_split #(.ADDR_W(ADDR_W), .MAX_BEATS(MAX_BEATS)) u_split (
    .clk(clk),
    .rst(rst),
    .load(load),
    .next(next),
    .start(wd_req ? wd_addr : rd_addr),
    .len(wd_req ? wd_len : rd_len),
    .addr(sub_addr),
    .sub_len(sub_len),
    .remaining(remaining)
  );
  assign axi.axi_awaddr = sub_addr;
  assign axi.axi_awlen = sub_len;
  assign axi.axi_araddr = sub_addr;
  assign axi.axi_arlen = sub_len;
  assign axi.axi_awvalid = state == S_WA;
  assign axi.axi_wvalid = state == S_WD;
  assign axi.axi_arvalid = state == S_RA;
  assign axi.axi_wlast = axi.axi_wvalid && beat == sub_len;
  assign axi.axi_wdata = axi.axi_wvalid ? wfifo_rd_data : '0;
  assign axi.axi_wstrb = '1;
  assign wfifo_rd_en = w_hs;
  assign wd_finish = state == S_FIN && is_wr;
  assign rd_finish = state == S_FIN && !is_wr;
  always_ff @(posedge clk)
    if (rst) begin
      state <= S_IDLE;
      is_wr <= 1'b0;
      beat <= '0;
      gcnt <= '0;
      rfifo_wr_en <= 1'b0;
      rfifo_wr_data <= '0;
      err_rlast <= 1'b0;
    end else begin
      rfifo_wr_en <= r_beat;
      if (r_beat) rfifo_wr_data <= axi.axi_rdata;
      case (state)
        S_IDLE: if (load) begin
          is_wr <= wd_req;
          state <= (wd_req ? wd_len : rd_len) == '0 ? S_FIN : wd_req ? S_WA : S_RA;
        end
        S_WA: if (axi.axi_awready) begin
          state <= S_WD;
          beat <= '0;
        end
        S_WD: if (axi.axi_wready) begin
          beat <= beat + AXI_LEN_W'(1);
          if (axi.axi_wlast) state <= last_sub ? S_FIN : S_WA;
        end
        S_RA: if (axi.axi_arready) begin
          state <= S_RD;
          beat <= '0;
        end
        S_RD: if (axi.axi_rvalid) begin
          beat <= beat + AXI_LEN_W'(1);
          // the beat count ends the sub-burst; rlast is only cross-checked
          if (axi.axi_rlast != (beat == sub_len)) err_rlast <= 1'b1;
          if (beat == sub_len) state <= last_sub ? S_FIN : S_RA;
        end
        S_FIN: begin
          state <= S_GUARD;
          gcnt <= '0;
        end
        S_GUARD: if (gcnt == 16'(GUARD_CYC - 1)) state <= S_IDLE; else gcnt <= gcnt + 16'd1;
        default: state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_ddr3_burst_engine.sv
// tb_ddr3_burst_engine: scoreboard bench for ddr3_burst_engine with a reactive AXI slave and FIFO models
module tb_ddr3_burst_engine;
  import ddr3_pkg::*;
  localparam int DW = 256;
  localparam int AW = 28;
  localparam int MB = DEF_MAX_BEATS;
  localparam int GC = DEF_GUARD_CYC;
  logic clk = 0;
  logic rst = 1;
  logic init_done = 0;
  logic wd_req = 0;
  logic [AW-1:0] wd_addr = '0;
  logic [9:0] wd_len = '0;
  logic wd_finish;
  logic rd_req = 0;
  logic [AW-1:0] rd_addr = '0;
  logic [9:0] rd_len = '0;
  logic rd_finish;
  logic wfifo_rd_en;
  logic [DW-1:0] wfifo_rd_data;
  logic rfifo_wr_en;
  logic [DW-1:0] rfifo_wr_data;
  logic err_rlast;
  int tests = 0;
  int fails = 0;
  int wptr = 0;
  int wtot = 0;
  int wb = 0;
  int wfin = 0;
  int rfin = 0;
  int rb = 0;
  int bad_pos = -1;
  bit rnd_rdy = 0;
  logic [7:0] cur_awlen = '0;
  logic [35:0] aw_log[$];
  logic [35:0] ar_log[$];
  logic [DW-1:0] r_got[$];
  logic [DW-1:0] r_exp[$];
  int rq[$];
  typedef struct {
    bit wr;
    bit rnd;
    logic [AW-1:0] addr;
    int len;
    int nb;
    logic [AW-1:0] last_addr;
    int last_len;
  } vec_t;
  vec_t tbl[8];

  always #5 clk = ~clk;

  ddr3_burst_engine_if #(.DATA_W(DW), .ADDR_W(AW)) ax ();

  ddr3_burst_engine #(.DATA_W(DW), .ADDR_W(AW), .MAX_BEATS(MB), .GUARD_CYC(GC)) dut (
    .clk(clk),
    .rst(rst),
    .ddr3_init_done(init_done),
    .wd_req(wd_req),
    .wd_addr(wd_addr),
    .wd_len(wd_len),
    .wd_finish(wd_finish),
    .rd_req(rd_req),
    .rd_addr(rd_addr),
    .rd_len(rd_len),
    .rd_finish(rd_finish),
    .wfifo_rd_en(wfifo_rd_en),
    .wfifo_rd_data(wfifo_rd_data),
    .rfifo_wr_en(rfifo_wr_en),
    .rfifo_wr_data(rfifo_wr_data),
    .axi(ax),
    .err_rlast(err_rlast)
  );

  function automatic logic [DW-1:0] data_of(int i);
    logic [31:0] w;
    w = 32'(i) * 32'h9E3779B1 ^ 32'h0000A5A5;
    return {8{w}};
  endfunction

  function automatic void chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void chki(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // show-ahead write FIFO: head is a known function of how many beats were popped
  assign wfifo_rd_data = data_of(wptr);
  always @(posedge clk) if (wfifo_rd_en) wptr <= wptr + 1;

  // AXI slave: drive readies and R beats 2ns after the edge, observe the settled bus 1ns later
  always @(posedge clk) begin
    logic [DW-1:0] d;
    #2;
    if (rst) begin
      rq.delete();
      rb = 0;
    end
    ax.axi_awready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    ax.axi_wready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    ax.axi_arready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    if (rq.size() > 0 && (!rnd_rdy || $urandom_range(0, 2) != 0)) begin
      for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom();
      ax.axi_rvalid = 1'b1;
      ax.axi_rdata = d;
      ax.axi_rlast = rb == (bad_pos >= 0 ? bad_pos : rq[0] - 1);
      r_exp.push_back(d);
      rb++;
      if (rb == rq[0]) begin
        void'(rq.pop_front());
        rb = 0;
      end
    end else begin
      ax.axi_rvalid = 1'b0;
      ax.axi_rlast = 1'b0;
      ax.axi_rdata = '0;
    end
    #1;
    if (ax.axi_awvalid && ax.axi_awready) begin
      aw_log.push_back({ax.axi_awaddr, ax.axi_awlen});
      cur_awlen = ax.axi_awlen;
      wb = 0;
    end
    if (ax.axi_wvalid && ax.axi_wready) begin
      chk("wdata", ax.axi_wdata, data_of(wtot));
      chki("wlast", int'(ax.axi_wlast), int'(wb == int'(cur_awlen)));
      wtot++;
      wb++;
    end
    if (ax.axi_arvalid && ax.axi_arready) begin
      ar_log.push_back({ax.axi_araddr, ax.axi_arlen});
      rq.push_back(int'(ax.axi_arlen) + 1);
    end
    if (rfifo_wr_en) r_got.push_back(rfifo_wr_data);
    if (wd_finish) wfin++;
    if (rd_finish) rfin++;
  end

  // issue one command, wait for its finish, then compare everything against the sub-burst model
  task automatic run_cmd(input bit wr, input logic [AW-1:0] a, input int len, input bit exp_err);
    logic [35:0] exp_b[$];
    logic [35:0] got;
    int done;
    int sub;
    int cyc;
    int p0;
    done = 0;
    cyc = 0;
    aw_log.delete();
    ar_log.delete();
    r_got.delete();
    r_exp.delete();
    wfin = 0;
    rfin = 0;
    while (done < len) begin
      sub = len - done > MB ? MB : len - done;
      exp_b.push_back({a + AW'(done), 8'(sub - 1)});
      done += sub;
    end
    @(posedge clk);
    #1;
    p0 = wptr;
    if (wr) begin
      wd_addr = a;
      wd_len = 10'(len);
      wd_req = 1;
    end else begin
      rd_addr = a;
      rd_len = 10'(len);
      rd_req = 1;
    end
    while (wfin + rfin == 0 && cyc < 4000) begin
      @(posedge clk);
      #4;
      cyc++;
    end
    wd_req = 0;
    rd_req = 0;
    chki("timeout", int'(cyc >= 4000), 0);
    repeat (GC + 4) @(posedge clk);
    #4;
    chki("wd_finish_cnt", wfin, int'(wr));
    chki("rd_finish_cnt", rfin, int'(!wr));
    chki("nburst", wr ? aw_log.size() : ar_log.size(), exp_b.size());
    chki("stray_burst", wr ? ar_log.size() : aw_log.size(), 0);
    for (int i = 0; i < exp_b.size(); i++) begin
      got = '0;
      if (wr && aw_log.size() > i) got = aw_log[i];
      if (!wr && ar_log.size() > i) got = ar_log[i];
      chk("burst_addr_len", DW'(got), DW'(exp_b[i]));
    end
    chki("wfifo_pops", wptr - p0, wr ? len : 0);
    chki("rfifo_pushes", r_got.size(), wr ? 0 : len);
    for (int i = 0; i < r_exp.size() && i < r_got.size(); i++) chk("rfifo_data", r_got[i], r_exp[i]);
    chki("err_rlast", int'(err_rlast), int'(exp_err));
  endtask

  initial begin
    int cyc;
    int gap;
    int ws;
    int seen;
    logic [35:0] lg;
    tbl[0] = '{1, 0, 28'h000_0000, 16, 1, 28'h000_0000, 15};
    tbl[1] = '{1, 0, 28'h000_0100, 40, 3, 28'h000_0120, 7};
    tbl[2] = '{0, 1, 28'h000_0040, 8, 1, 28'h000_0040, 7};
    tbl[3] = '{0, 1, 28'hFFF_FFF8, 20, 2, 28'h000_0008, 3};
    tbl[4] = '{1, 1, 28'h000_0003, 17, 2, 28'h000_0013, 0};
    tbl[5] = '{1, 0, 28'h000_0000, 0, 0, 28'h000_0000, 0};
    tbl[6] = '{0, 0, 28'h000_0200, 1023, 64, 28'h000_05F0, 14};
    tbl[7] = '{0, 0, 28'h000_0055, 1, 1, 28'h000_0055, 0};
    repeat (3) @(posedge clk);
    #4;
    chki("rst_ctrl", int'({ax.axi_awvalid, ax.axi_wvalid, ax.axi_arvalid, ax.axi_wlast, wfifo_rd_en,
                           rfifo_wr_en, wd_finish, rd_finish, err_rlast}), 0);
    chk("rst_bus", DW'({ax.axi_awaddr, ax.axi_awlen, ax.axi_araddr, ax.axi_arlen}), '0);
    chk("rst_wdata", ax.axi_wdata, '0);
    chk("rst_rfifo_data", rfifo_wr_data, '0);
    chk("rst_wstrb", DW'(ax.axi_wstrb), DW'(32'hFFFF_FFFF));
    rst = 0;
    // requests must be ignored until calibration completes
    wd_addr = 28'h10;
    wd_len = 10'd4;
    wd_req = 1;
    seen = 0;
    repeat (10) begin
      @(posedge clk);
      #4;
      seen |= int'(ax.axi_awvalid);
    end
    chki("no_cmd_before_init", seen, 0);
    wd_req = 0;
    init_done = 1;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      rnd_rdy = tbl[i].rnd;
      run_cmd(tbl[i].wr, tbl[i].addr, tbl[i].len, 0);
      chki("tbl_nburst", tbl[i].wr ? aw_log.size() : ar_log.size(), tbl[i].nb);
      if (tbl[i].nb > 0 && (tbl[i].wr ? aw_log.size() : ar_log.size()) > 0) begin
        lg = tbl[i].wr ? aw_log[$] : ar_log[$];
        chki("tbl_last_addr", int'(lg[35:8]), int'(tbl[i].last_addr));
        chki("tbl_last_len", int'(lg[7:0]), tbl[i].last_len);
      end
    end
    // simultaneous requests: write wins, held wd_req is ignored through the guard, then the read runs
    rnd_rdy = 0;
    aw_log.delete();
    ar_log.delete();
    wfin = 0;
    rfin = 0;
    @(posedge clk);
    #1;
    wd_addr = 28'h10;
    wd_len = 10'd4;
    rd_addr = 28'h20;
    rd_len = 10'd4;
    wd_req = 1;
    rd_req = 1;
    cyc = 0;
    while (wfin == 0 && cyc < 200) begin
      @(posedge clk);
      #4;
      cyc++;
    end
    chki("both_write_first_aw", aw_log.size(), 1);
    chki("both_write_first_ar", ar_log.size(), 0);
    for (int i = 0; i < GC; i++) begin
      @(posedge clk);
      #4;
      chki("guard_quiet", int'(ax.axi_awvalid || ax.axi_arvalid), 0);
    end
    wd_req = 0;
    gap = GC;
    while (!ax.axi_arvalid && gap < 200) begin
      @(posedge clk);
      #4;
      gap++;
    end
    chki("guard_gap", gap, GC + 2);
    cyc = 0;
    while (rfin == 0 && cyc < 200) begin
      @(posedge clk);
      #4;
      cyc++;
    end
    rd_req = 0;
    repeat (GC + 4) @(posedge clk);
    #4;
    chki("both_rd_finish", rfin, 1);
    chki("both_wd_finish", wfin, 1);
    chki("both_aw_total", aw_log.size(), 1);
    chki("both_ar_total", ar_log.size(), 1);
    // reset in the middle of a 16-beat write
    wfin = 0;
    @(posedge clk);
    #1;
    wd_addr = 28'h0;
    wd_len = 10'd16;
    wd_req = 1;
    ws = wtot;
    cyc = 0;
    while (wtot - ws < 5 && cyc < 200) begin
      @(posedge clk);
      #4;
      cyc++;
    end
    rst = 1;
    wd_req = 0;
    @(posedge clk);
    #4;
    chki("rst_mid_outputs", int'({ax.axi_awvalid, ax.axi_wvalid, ax.axi_arvalid, wfifo_rd_en,
                                  rfifo_wr_en, wd_finish, rd_finish}), 0);
    rst = 0;
    repeat (20) @(posedge clk);
    #4;
    chki("rst_mid_no_finish", wfin, 0);
    run_cmd(1, 28'h40, 16, 0);
    // rlast on beat 2 of 4: all beats still pushed, error latched; then an empty write
    rnd_rdy = 1;
    bad_pos = 1;
    run_cmd(0, 28'h80, 4, 1);
    bad_pos = -1;
    run_cmd(1, 28'h0, 0, 1);
    @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk);
    #4;
    chki("err_rlast_cleared", int'(err_rlast), 0);
    rst = 0;
    repeat (2) @(posedge clk);
    // randomized commands with random backpressure and R gaps
    for (int n = 0; n < 30; n++)
      run_cmd(1'($urandom_range(0, 1)), AW'($urandom()), int'($urandom_range(0, 70)), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
